// File: rtl/body_readback.sv
// Snapshot reader for the N-body simulator: stalls the simulator, copies x/y/z
// positions into a private buffer, then serves that buffer over the host bus.
module body_readback #(
  parameter int BODIES     = 512,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int IDX_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  step_done,
  input  logic                  sim_idle,
  output logic                  sim_hold,
  output logic                  src_rd_en,
  output logic [IDX_WIDTH-1:0]  src_idx,
  input  logic [DATA_WIDTH-1:0] src_x,
  input  logic [DATA_WIDTH-1:0] src_y,
  input  logic [DATA_WIDTH-1:0] src_z
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_COPY  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int BI_W = ADDR_WIDTH - 3;

  logic [DATA_WIDTH-1:0] snap_x [BODIES];
  logic [DATA_WIDTH-1:0] snap_y [BODIES];
  logic [DATA_WIDTH-1:0] snap_z [BODIES];

  logic [2:0]           state;
  logic                 snap_valid, busy, overrun, auto_en;
  logic [31:0]          frame_count;
  logic                 rd_vld;
  logic [IDX_WIDTH-1:0] rd_idx;

  logic                  acc_rd, ctrl_wr, sel_snap, sel_stat, idx_ok, trigger;
  logic [BI_W-1:0]       bus_idx;
  logic [DATA_WIDTH-1:0] status_word, snap_word;
  logic                  wd_unused;

  assign acc_rd    = chipselect & read;
  assign sel_snap  = addr[ADDR_WIDTH-1];
  assign sel_stat  = ~addr[ADDR_WIDTH-1] & ~addr[0];
  assign ctrl_wr   = chipselect & write & ~addr[ADDR_WIDTH-1] & addr[0];
  assign trigger   = (ctrl_wr & write_data[0]) | (step_done & auto_en);
  assign wd_unused = ^write_data[DATA_WIDTH-1:2];

  // The full index field is compared so out-of-range bodies read as zero
  // instead of aliasing onto a lower index.
  assign bus_idx = addr[ADDR_WIDTH-2:2];
  assign idx_ok  = 32'(bus_idx) < BODIES;

  always_comb begin
    status_word        = '0;
    status_word[0]     = snap_valid;
    status_word[1]     = busy;
    status_word[2]     = overrun;
    status_word[3]     = auto_en;
    status_word[47:16] = frame_count;
  end

  always_comb begin
    snap_word = '0;
    if (idx_ok) begin
      case (addr[1:0])
        2'd0:    snap_word = snap_x[bus_idx[IDX_WIDTH-1:0]];
        2'd1:    snap_word = snap_y[bus_idx[IDX_WIDTH-1:0]];
        2'd2:    snap_word = snap_z[bus_idx[IDX_WIDTH-1:0]];
        default: snap_word = '0;
      endcase
    end
  end

  // Source data lags the issued index by one cycle; rd_vld/rd_idx carry it.
  always_ff @(posedge clk) begin
    if (rd_vld) begin
      snap_x[rd_idx] <= src_x;
      snap_y[rd_idx] <= src_y;
      snap_z[rd_idx] <= src_z;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data   <= '0;
      sim_hold    <= 1'b0;
      src_rd_en   <= 1'b0;
      src_idx     <= '0;
      snap_valid  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      auto_en     <= 1'b0;
      frame_count <= '0;
      state       <= S_IDLE;
      rd_vld      <= 1'b0;
      rd_idx      <= '0;
    end else begin
      rd_vld <= src_rd_en;
      rd_idx <= src_idx;

      if (acc_rd) begin
        if (sel_snap)      read_data <= snap_word;
        else if (sel_stat) read_data <= status_word;
        else               read_data <= {{(DATA_WIDTH-2){1'b0}}, auto_en, 1'b0};
      end

      if (ctrl_wr) auto_en <= write_data[1];

      // A fresh overrun beats a simultaneous STATUS read-clear.
      if (trigger && state != S_IDLE) overrun <= 1'b1;
      else if (acc_rd && sel_stat)    overrun <= 1'b0;

      case (state)
        S_IDLE: if (trigger) begin
          state      <= S_REQ;
          sim_hold   <= 1'b1;
          busy       <= 1'b1;
          snap_valid <= 1'b0;
        end
        S_REQ: if (sim_idle) begin
          state     <= S_COPY;
          src_rd_en <= 1'b1;
          src_idx   <= '0;
        end
        S_COPY: begin
          if (src_idx == IDX_WIDTH'(BODIES-1)) begin
            src_rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            src_idx <= src_idx + 1'b1;
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          snap_valid  <= 1'b1;
          frame_count <= frame_count + 32'd1;
          sim_hold    <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_body_readback.sv
// Bench for body_readback: deadline-based snapshot model checked every cycle,
// plus directed vectors with hand-computed values.
module tb_body_readback;
  localparam int BODIES = 512;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int IW = 9;

  logic          clk = 1'b0, rst = 1'b1;
  logic          chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] write_data = '0, read_data;
  logic          step_done = 1'b0, sim_idle = 1'b0, sim_hold, src_rd_en;
  logic [IW-1:0] src_idx;
  logic [DW-1:0] src_x = '0, src_y = '0, src_z = '0;

  always #5 clk = ~clk;

  body_readback #(.BODIES(BODIES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .read(read), .write(write),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .step_done(step_done), .sim_idle(sim_idle), .sim_hold(sim_hold),
    .src_rd_en(src_rd_en), .src_idx(src_idx),
    .src_x(src_x), .src_y(src_y), .src_z(src_z)
  );

  // simulator position memories, registered read
  logic [DW-1:0] pos_x [BODIES];
  logic [DW-1:0] pos_y [BODIES];
  logic [DW-1:0] pos_z [BODIES];
  always @(posedge clk) if (src_rd_en) begin
    src_x <= pos_x[src_idx];
    src_y <= pos_y[src_idx];
    src_z <= pos_z[src_idx];
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: a snapshot completes BODIES+2 cycles after sim_idle is seen while waiting
  logic          m_snap = 0, m_busy = 0, m_wait = 0, m_over = 0, m_auto = 0, m_have = 0;
  logic [31:0]   m_frame = 0;
  longint        cyc = 0, m_done = 0;
  logic [DW-1:0] m_rd = '0;
  logic          m_rd_known = 0;
  logic [DW-1:0] m_x [BODIES];
  logic [DW-1:0] m_y [BODIES];
  logic [DW-1:0] m_z [BODIES];

  always begin
    logic acc, ctrl, trig, done_now, is_stat;
    int bi;
    @(posedge clk);
    cyc++;
    if (rst) begin
      if (m_busy) m_have = 0;
      m_snap = 0; m_busy = 0; m_wait = 0; m_over = 0; m_auto = 0; m_frame = 0;
      m_rd = '0; m_rd_known = 1;
    end else begin
      acc     = chipselect && read;
      is_stat = !addr[AW-1] && !addr[0];
      if (acc) begin
        if (is_stat) begin
          m_rd = {16'h0, m_frame, 12'h0, m_auto, m_over, m_busy, m_snap};
          m_rd_known = 1;
        end else if (addr[AW-1]) begin
          bi = int'(addr[AW-2:2]);
          if (addr[1:0] == 2'd3 || bi >= BODIES) begin
            m_rd = '0; m_rd_known = 1;
          end else if (m_have && !m_busy) begin
            m_rd = (addr[1:0] == 2'd0) ? m_x[bi] : (addr[1:0] == 2'd1) ? m_y[bi] : m_z[bi];
            m_rd_known = 1;
          end else m_rd_known = 0;
        end else m_rd_known = 0;
      end
      ctrl     = chipselect && write && !addr[AW-1] && addr[0];
      trig     = (ctrl && write_data[0]) || (step_done && m_auto);
      done_now = m_busy && !m_wait && cyc == m_done;
      if (m_busy && m_wait && sim_idle) begin
        m_wait = 0;
        m_done = cyc + BODIES + 2;
      end
      if (acc && is_stat) m_over = 0;
      if (trig) begin
        if (m_busy) m_over = 1;
        else begin m_busy = 1; m_wait = 1; m_snap = 0; end
      end
      if (done_now) begin
        m_busy = 0; m_snap = 1; m_frame = m_frame + 1; m_have = 1;
        for (int i = 0; i < BODIES; i++) begin
          m_x[i] = pos_x[i]; m_y[i] = pos_y[i]; m_z[i] = pos_z[i];
        end
      end
      if (ctrl) m_auto = write_data[1];
    end
    #1;
    chk("sim_hold", {63'd0, sim_hold}, {63'd0, m_busy});
    if (!m_busy) chk("src_rd_en idle", {63'd0, src_rd_en}, 64'd0);
    if (m_rd_known) chk("read_data", read_data, m_rd);
  end

  task automatic load_src(input logic [DW-1:0] off);
    for (int i = 0; i < BODIES; i++) begin
      pos_x[i] = DW'(i) + off;
      pos_y[i] = DW'(i) + off + 64'h1000;
      pos_z[i] = DW'(i) + off + 64'h2000;
    end
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); chipselect = 1; write = 1; addr = a; write_data = d;
    @(negedge clk); chipselect = 0; write = 0;
  endtask

  task automatic bus_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk); chipselect = 1; read = 1; addr = a;
    @(negedge clk); chipselect = 0; read = 0; d = read_data;
  endtask

  task automatic wait_hold_low(output longint drop_cyc);
    int n = 0;
    while (sim_hold === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (sim_hold !== 1'b0) begin
      errors++;
      $display("FAIL copy timeout: sim_hold still %b after %0d cycles", sim_hold, n);
    end
    drop_cyc = cyc;
  endtask

  task automatic snapshot_ctrl();
    longint t;
    bus_wr(16'h0001, 64'h1);
    repeat (3) @(negedge clk);
    sim_idle = 1;
    wait_hold_low(t);
    sim_idle = 0;
  endtask

  task automatic snapshot_step();
    longint t;
    @(negedge clk); step_done = 1;
    @(negedge clk); step_done = 0;
    repeat (3) @(negedge clk);
    sim_idle = 1;
    wait_hold_low(t);
    sim_idle = 0;
  endtask

  initial begin
    logic [DW-1:0] d, d0, d1, d2;
    longint t0, t1, start;
    int n;
    load_src(64'h0);
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset read_data", read_data, 64'd0);
    chk("reset sim_hold", {63'd0, sim_hold}, 64'd0);
    chk("reset src_rd_en", {63'd0, src_rd_en}, 64'd0);
    chk("reset src_idx", DW'(src_idx), 64'd0);
    bus_rd(16'h0000, d); chk("reset status", d, 64'd0);

    // 1: manual snapshot and copy latency
    bus_wr(16'h0001, 64'h1);
    chk("hold after ctrl", {63'd0, sim_hold}, 64'd1);
    repeat (3) @(negedge clk);
    sim_idle = 1; t0 = cyc + 1;
    wait_hold_low(t1);
    sim_idle = 0;
    chk("copy latency", DW'(t1 - t0), 64'd514);
    bus_rd(16'h8015, d); chk("body5 y", d, 64'h1005);
    bus_rd(16'h0000, d); chk("status t1", d, 64'h0000_0000_0001_0001);
    bus_rd(16'h87FE, d); chk("body511 z", d, 64'h21FF);
    bus_rd(16'h8000, d); chk("body0 x", d, 64'h0);

    // 2: auto mode, two steps 1000 cycles apart, src updated between
    bus_wr(16'h0001, 64'h2);
    start = cyc;
    snapshot_step();
    load_src(64'h4000);
    n = 0;
    while (cyc < start + 1000 && n < 2000) begin @(negedge clk); n++; end
    snapshot_step();
    bus_rd(16'h0000, d); chk("status t2", d, 64'h0000_0000_0003_0009);
    bus_rd(16'h801E, d); chk("body7 z new", d, 64'h6007);

    // 3: collision during COPY is one dropped trigger
    @(negedge clk); step_done = 1;
    @(negedge clk); step_done = 0;
    repeat (3) @(negedge clk);
    sim_idle = 1;
    repeat (20) @(negedge clk);
    chipselect = 1; write = 1; addr = 16'h0001; write_data = 64'h1; step_done = 1;
    @(negedge clk); chipselect = 0; write = 0; step_done = 0;
    wait_hold_low(t1);
    sim_idle = 0;
    repeat (5) @(negedge clk);
    chk("no extra snapshot", {63'd0, sim_hold}, 64'd0);
    bus_rd(16'h0000, d); chk("status overrun", d, 64'h0000_0000_0004_0005);
    bus_rd(16'h0000, d); chk("status cleared", d, 64'h0000_0000_0004_0001);

    // 4: out-of-range reads and back-to-back reads
    bus_rd(16'h8017, d); chk("component 3", d, 64'h0);
    bus_rd(16'h8960, d); chk("body 600", d, 64'h0);
    @(negedge clk); chipselect = 1; read = 1; addr = 16'h8028;
    @(negedge clk); d0 = read_data; addr = 16'h802D;
    @(negedge clk); d1 = read_data; addr = 16'h0000;
    @(negedge clk); d2 = read_data; chipselect = 0; addr = 16'h8000;
    @(negedge clk); read = 0;
    chk("b2b body10 x", d0, 64'h400A);
    chk("b2b body11 y", d1, 64'h500B);
    chk("b2b status", d2, 64'h0000_0000_0004_0001);
    chk("unaccepted read holds", read_data, 64'h0000_0000_0004_0001);

    // 5: reset mid-copy, then a clean snapshot
    bus_wr(16'h0001, 64'h1);
    repeat (3) @(negedge clk);
    sim_idle = 1;
    n = 0;
    while (!(src_rd_en === 1'b1 && src_idx == IW'(200)) && n < 2000) begin @(negedge clk); n++; end
    chk("reached idx 200", DW'(src_idx), 64'd200);
    rst = 1;
    @(negedge clk); rst = 0; sim_idle = 0;
    chk("rst sim_hold", {63'd0, sim_hold}, 64'd0);
    chk("rst src_rd_en", {63'd0, src_rd_en}, 64'd0);
    bus_rd(16'h0000, d); chk("rst status", d, 64'd0);
    snapshot_ctrl();
    bus_rd(16'h0000, d); chk("status after rst", d, 64'h0000_0000_0001_0001);
    bus_rd(16'h84B1, d); chk("body300 y", d, 64'h512C);

    // 6: frame_count wrap
    @(negedge clk);
    force dut.frame_count = 32'hFFFF_FFFF;
    m_frame = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_count;
    bus_rd(16'h0000, d); chk("frame max", d, 64'h0000_FFFF_FFFF_0001);
    snapshot_ctrl();
    bus_rd(16'h0000, d); chk("frame wrap", d, 64'h0000_0000_0000_0001);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
